// File: rtl/interrupt_controller_n.sv
// Parametrised interrupt controller: per-source edge capture, fixed priority
// (lowest index wins), delayed-EI master enable and ack/reti service handshake.

module intc_src (
  input  logic iClock,
  input  logic iReset,
  input  logic req,
  input  logic wr_en,
  input  logic wr_val,
  input  logic ack_clr,
  output logic flag
);
  logic prev;
  logic rise;

  assign rise = req & ~prev;

  // Hardware set is applied last so it beats both a CPU write and an ack clear.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      prev <= 1'b0;
      flag <= 1'b0;
    end else begin
      prev <= req;
      flag <= ((wr_en ? wr_val : flag) & ~ack_clr) | rise;
    end
  end
endmodule

module interrupt_controller_n #(
  parameter int          NUM_SRC       = 5,
  parameter logic [15:0] VECTOR_BASE   = 16'h0040,
  parameter int          VECTOR_STRIDE = 8
) (
  input  logic               iClock,
  input  logic               iReset,
  input  logic               iMcuWe,
  input  logic [3:0]         iMcuRegSelect,
  input  logic [7:0]         iMcuWriteData,
  output logic [7:0]         oInterruptEnableRegister,
  output logic [7:0]         oInterruptFlag,
  input  logic [NUM_SRC-1:0] iInterruptRequest,
  input  logic               iEI,
  input  logic               iDI,
  input  logic               iReti,
  input  logic               iAck,
  output logic               oIrq,
  output logic [15:0]        oVector,
  output logic [NUM_SRC-1:0] oServicing,
  output logic               oIme
);
  typedef enum logic {IDLE, SERVE} state_t;

  state_t             state, state_n;
  logic [NUM_SRC-1:0] ie;
  logic [NUM_SRC-1:0] iflag;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] ack_clr;
  logic [2:0]         winner;
  logic               accept;
  logic               ime, ime_n;
  logic               ei_pend, ei_pend_n;
  logic               ie_we, if_we;
  logic               unused_wdata;

  assign unused_wdata = ^iMcuWriteData;
  assign ie_we   = iMcuWe && (iMcuRegSelect == 4'h0);
  assign if_we   = iMcuWe && (iMcuRegSelect == 4'hF);
  assign pending = iflag & ie;
  assign oIrq    = ime && (pending != '0) && (state == IDLE);
  assign accept  = iAck && oIrq;
  assign oIme    = ime;

  assign oInterruptEnableRegister = 8'(ie);
  assign oInterruptFlag           = 8'(iflag);

  always_comb begin
    winner = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (pending[i]) winner = 3'(i);
  end

  genvar g;
  generate
    for (g = 0; g < NUM_SRC; g++) begin : g_src
      assign ack_clr[g] = accept && (winner == 3'(g));
      intc_src u_src (
        .iClock  (iClock),
        .iReset  (iReset),
        .req     (iInterruptRequest[g]),
        .wr_en   (if_we),
        .wr_val  (iMcuWriteData[g]),
        .ack_clr (ack_clr[g]),
        .flag    (iflag[g])
      );
    end
  endgenerate

  always_ff @(posedge iClock) begin
    if (iReset)     ie <= '0;
    else if (ie_we) ie <= iMcuWriteData[NUM_SRC-1:0];
  end

  // Later assignments take priority; DI overrides everything else.
  always_comb begin
    ime_n     = ime;
    ei_pend_n = ei_pend;
    if (ei_pend) begin
      ime_n     = 1'b1;
      ei_pend_n = 1'b0;
    end
    if (iEI)   ei_pend_n = 1'b1;
    if (iReti) ime_n     = 1'b1;
    if (accept) begin
      ime_n     = 1'b0;
      ei_pend_n = 1'b0;
    end
    if (iDI) begin
      ime_n     = 1'b0;
      ei_pend_n = 1'b0;
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      ime     <= 1'b0;
      ei_pend <= 1'b0;
    end else begin
      ime     <= ime_n;
      ei_pend <= ei_pend_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = SERVE;
      SERVE:   if (iReti)  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      oVector    <= 16'h0000;
      oServicing <= '0;
    end else if (accept) begin
      oVector    <= VECTOR_BASE + 16'(winner) * 16'(VECTOR_STRIDE);
      oServicing <= NUM_SRC'(1) << winner;
    end else if (state == SERVE && iReti) begin
      oServicing <= '0;
    end
  end
endmodule

// File: doc/interrupt_controller_n.md
Name: interrupt_controller_n

Overview:
- Parametrised, sequential successor to the fixed 5-source interrupt controller.
- Supports NUM_SRC sources with rising-edge request capture and fixed priority (lowest index wins).
- Adds a master enable (IME) with a one-cycle-delayed EI, and an acknowledge/return handshake with the CPU that outputs the service vector.
- Sits between the peripherals (PPU, timer, serial, joypad, …) and the CPU core; IE and IF are mapped through the MCU register bus.

Parameters:
- NUM_SRC, 5, number of interrupt sources (1..8); bits at and above NUM_SRC are unimplemented.
- VECTOR_BASE, 16'h0040, vector address of source 0.
- VECTOR_STRIDE, 8, address increment per source index.

Ports:
- iClock  in  1  system clock; all state changes on its rising edge.
- iReset  in  1  synchronous, active-high reset.
- iMcuWe  in  1  register write strobe.
- iMcuRegSelect  in  4  register select: 4'h0 = IE, 4'hF = IF.
- iMcuWriteData  in  8  write data.
- oInterruptEnableRegister  out  8  IE readback.
- oInterruptFlag  out  8  IF readback.
- iInterruptRequest  in  NUM_SRC  level requests from the peripherals.
- iEI  in  1  CPU executed EI (1-cycle pulse).
- iDI  in  1  CPU executed DI (1-cycle pulse).
- iReti  in  1  CPU executed RETI (1-cycle pulse).
- iAck  in  1  CPU accepts the interrupt (1-cycle pulse).
- oIrq  out  1  interrupt request to the CPU.
- oVector  out  16  service address of the accepted source.
- oServicing  out  NUM_SRC  one-hot index of the source being serviced.
- oIme  out  1  master enable state.

Behaviour:
- Reset: IE, IF, IME, EI-pending, rReqPrev, oServicing, oVector all 0; FSM = IDLE; oIrq = 0. Reset wins over every other input in the same cycle.
- Unimplemented bits (index >= NUM_SRC) of IE and IF are always stored and read as 0.
- IE: loaded from iMcuWriteData[NUM_SRC-1:0] when iMcuWe && select == 0; takes effect the next cycle.
- Edge detect: rise = iInterruptRequest & ~rReqPrev; rReqPrev <= iInterruptRequest every cycle.
  - A request held high sets IF only once.
  - A request already high at reset release counts as an edge.
- IF update, per bit, evaluated in this order:
  - base = CPU write value if iMcuWe && select == F, else current IF;
  - base cleared if the bit is the ack-clear bit;
  - then OR rise.
  - Hardware set therefore wins over both a CPU write and an ack clear in the same cycle.
- pending = IF & IE. winner = lowest set index of pending.
- IME:
  - iDI: IME <= 0 and EI-pending <= 0.
  - iEI: EI-pending <= 1; on the next cycle IME <= 1 and EI-pending <= 0. An iEI at cycle t gives oIme = 1 at t+2.
  - iDI in the same cycle as iEI, or the cycle after it, cancels the enable.
  - iReti: IME <= 1 immediately, visible at t+1. iDI in the same cycle as iReti wins.
- oIrq = IME && (pending != 0) && state == IDLE. Combinational from registers.
- FSM IDLE:
  - iAck while oIrq = 1 → capture winner.
    - oVector <= VECTOR_BASE + winner*VECTOR_STRIDE (16-bit, no overflow for legal parameters).
    - oServicing <= one-hot(winner).
    - Clear IF[winner]; IME <= 0 and EI-pending <= 0.
    - Next state = SERVE.
  - iAck while oIrq = 0 is ignored.
- FSM SERVE:
  - oVector and oServicing are held; iAck is ignored.
  - IF and IE keep updating normally.
  - iReti → IDLE, oServicing <= 0, IME <= 1; oVector retains its last value.
- The winner is sampled on the ack cycle. A higher-priority request arriving on that same cycle does not preempt it; it is serviced next.

Test Plan:
- Reset: assert iReset for 2 cycles with all request lines high → oInterruptFlag = 0x00, oInterruptEnableRegister = 0x00, oIrq = 0, oVector = 0x0000, oIme = 0. After release, IF = 0x1F one cycle later.
- Basic service: IE = 0x1F, pulse iEI, raise request bit 2 → IF = 0x04, oIrq = 1. Pulse iAck → oVector = 0x0050, oServicing = 0x04, IF = 0x00, oIme = 0, oIrq = 0. Pulse iReti → oIme = 1, state IDLE.
- Priority: IF = 0x14, IE = 0x1F, IME = 1, ack → oVector = 0x0050. Reti, ack → oVector = 0x0060, IF = 0x00.
- Collision: write IF = 0x00 in the same cycle as a rising edge on bit 0 → IF = 0x01. Ack of bit 3 in the same cycle as a rising edge on bit 3 → IF[3] = 1.
- EI/DI timing: iEI at t → oIme = 0 at t+1, 1 at t+2. Then iEI at t and iDI at t+1 → oIme stays 0.
- Level hold / param: request bit 1 held high for 10 cycles, serviced once → IF[1] stays 0 with no retrigger. With NUM_SRC = 3, writing IF = 0xFF reads back 0x07.
